stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
// Control FSM and time-keeping datapath for the SS.hh stopwatch. Sits between the clock
// divider and the 4-digit 7-seg driver. Takes the 1-cycle count pulse (tick, 100 Hz) and the
// display scan pulse (scan_tick), plus the three buttons. Sequences start/stop/lap/clear,
// keeps a 4-digit BCD count and a lap snapshot, and time-multiplexes one digit per scan slot.
// PARAMETERS
// SEC_TENS_MAX  5  largest seconds-tens digit; full scale is {SEC_TENS_MAX,9}.99
// WRAP          1  1: full scale + tick -> 00.00; 0: saturate at full scale
// PORTS
// clk          in   1   system clock
// reset        in   1   synchronous, active-high
// tick         in   1   count pulse, 1 clk wide
// scan_tick    in   1   display advance pulse, 1 clk wide
// btn_ss       in   1   start/stop, synchronised/debounced level
// btn_lap      in   1   lap freeze/release level
// btn_clr      in   1   clear level
// time_bcd     out  16  live count {s10,s1,h10,h1}
// digit_an     out  4   anode select, active-low one-hot
// digit_bcd    out  4   BCD value of the selected digit
// dp_n         out  1   decimal point, active-low
// running      out  1   high in RUN or LAP
// lap_active   out  1   high in LAP
// ovf          out  1   sticky full-scale flag
// BEHAVIOUR
// - Reset: state IDLE, time_bcd=0, lap reg=0, ovf=0, scan index=0, digit_an=4'b1110,
//   digit_bcd=0, dp_n=1, running=0, lap_active=0.
// - Edge detect: ev_x = btn_x & ~btn_x_q. btn_x_q resets to 0, so a button held through
//   reset gives no event. One event per press.
// - Event latency: the state changes at the same clk edge where ev_x is true. Outputs show
//   it 1 cycle after the button level is first sampled high.
// - Event priority in one cycle: clr > ss > lap. Lower-priority events that cycle are dropped.
// - FSM:
//   IDLE:  ev_ss->RUN.
//   RUN:   ev_ss->PAUSE; ev_lap->LAP and lap_reg<=time_bcd (pre-increment value that cycle).
//   LAP:   ev_ss->PAUSE; ev_lap->RUN.
//   PAUSE: ev_ss->RUN; ev_clr->IDLE with time_bcd<=0, ovf<=0.
//   ev_clr is ignored in RUN/LAP. ev_lap is ignored in IDLE/PAUSE.
// - Count: time_bcd increments on a clk edge with tick=1 when the current (pre-transition)
//   state is RUN or LAP. A tick in the same cycle as RUN->PAUSE is counted. A tick in the
//   same cycle as PAUSE->RUN is not.
// - BCD ripple: h1 9->0 carries to h10; h10 9->0 carries to s1; s1 9->0 carries to s10.
//   At full scale with a tick: WRAP=1 gives 00.00; WRAP=0 holds. Either way ovf<=1.
//   Every digit is always 0..9; s10 is always <= SEC_TENS_MAX.
// - Display source: lap_reg in LAP, time_bcd otherwise.
// - Scan index increments mod 4 on scan_tick. Index 0=h1 (an 1110), 1=h10 (1101),
//   2=s1 (1011, dp_n=0), 3=s10 (0111).
// - digit_an, digit_bcd and dp_n are registered. They update 1 cycle after the scan_tick
//   edge or the source change.
// - Reset mid-count or mid-LAP returns to the reset values on the next edge. No partial
//   state survives.
// TESTING
// T1 reset, pulse btn_ss, apply 150 ticks -> running=1, time_bcd=16'h0150.
// T2 from 01.50 in RUN, press btn_lap, apply 25 ticks -> digit_bcd shows 0150, time_bcd=16'h0175,
//    lap_active=1. Press btn_lap -> display shows 0175.
// T3 in RUN, press btn_clr -> no change. Press btn_ss, then btn_clr -> IDLE, time_bcd=0, running=0.
// T4 preload 59.99 (WRAP=1), one tick -> time_bcd=0, ovf=1. Same with WRAP=0 -> 16'h5999 held, ovf=1.
// T5 btn_ss and tick in the same cycle while at 00.10 in RUN -> PAUSE, time_bcd=16'h0011.
//    btn_clr+btn_ss together in PAUSE -> IDLE (clr wins).
// T6 4 scan_ticks at 12.34 -> (an,bcd,dp_n) sequence: (1101,3,1), (1011,2,0), (0111,1,1), (1110,4,1).

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - SS.hh stopwatch control FSM, BCD time-keeping and digit scan
module stopwatch_ctrl #(
   parameter int SEC_TENS_MAX = 5,
   parameter bit WRAP         = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        scan_tick,
   input  logic        btn_ss,
   input  logic        btn_lap,
   input  logic        btn_clr,
   output logic [15:0] time_bcd,
   output logic [3:0]  digit_an,
   output logic [3:0]  digit_bcd,
   output logic        dp_n,
   output logic        running,
   output logic        lap_active,
   output logic        ovf
);

   typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

   localparam logic [3:0]  S10_MAX    = 4'(SEC_TENS_MAX);
   localparam logic [15:0] FULL_SCALE = {S10_MAX, 4'h9, 4'h9, 4'h9};

   state_t      state;
   logic        btn_ss_q, btn_lap_q, btn_clr_q;
   logic        ev_ss, ev_lap, ev_clr;
   logic [15:0] lap_reg;
   logic [15:0] time_inc;
   logic [15:0] disp_src;
   logic        at_full;
   logic        count_en;
   logic [1:0]  scan_idx;

   // Rising-edge events with clr > ss > lap priority; losers are dropped
   assign ev_clr   = btn_clr & ~btn_clr_q;
   assign ev_ss    = btn_ss  & ~btn_ss_q  & ~ev_clr;
   assign ev_lap   = btn_lap & ~btn_lap_q & ~ev_clr & ~(btn_ss & ~btn_ss_q);
   assign at_full  = (time_bcd == FULL_SCALE);
   assign count_en = tick & ((state == RUN) || (state == LAP));
   assign disp_src = (state == LAP) ? lap_reg : time_bcd;

   // Next BCD count: ripple carry digit by digit, wrap or hold at full scale
   always_comb begin
      time_inc = time_bcd;
      if (at_full) begin
         time_inc = WRAP ? 16'h0000 : time_bcd;
      end else if (time_bcd[3:0] != 4'd9) begin
         time_inc[3:0] = time_bcd[3:0] + 4'd1;
      end else begin
         time_inc[3:0] = 4'd0;
         if (time_bcd[7:4] != 4'd9) begin
            time_inc[7:4] = time_bcd[7:4] + 4'd1;
         end else begin
            time_inc[7:4] = 4'd0;
            if (time_bcd[11:8] != 4'd9) begin
               time_inc[11:8] = time_bcd[11:8] + 4'd1;
            end else begin
               time_inc[11:8]  = 4'd0;
               time_inc[15:12] = time_bcd[15:12] + 4'd1;
            end
         end
      end
   end

   // Control FSM, counter, lap snapshot and overflow flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         btn_ss_q   <= 1'b0;
         btn_lap_q  <= 1'b0;
         btn_clr_q  <= 1'b0;
         time_bcd   <= 16'h0000;
         lap_reg    <= 16'h0000;
         ovf        <= 1'b0;
         running    <= 1'b0;
         lap_active <= 1'b0;
      end else begin
         btn_ss_q  <= btn_ss;
         btn_lap_q <= btn_lap;
         btn_clr_q <= btn_clr;
         if (count_en) begin
            time_bcd <= time_inc;
            if (at_full) ovf <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (ev_ss) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (ev_ss) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end else if (ev_lap) begin
                  state      <= LAP;
                  lap_active <= 1'b1;
                  lap_reg    <= time_bcd;
               end
            end
            LAP: begin
               if (ev_ss) begin
                  state      <= PAUSE;
                  running    <= 1'b0;
                  lap_active <= 1'b0;
               end else if (ev_lap) begin
                  state      <= RUN;
                  lap_active <= 1'b0;
               end
            end
            PAUSE: begin
               if (ev_clr) begin
                  state    <= IDLE;
                  time_bcd <= 16'h0000;
                  ovf      <= 1'b0;
               end else if (ev_ss) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Digit scan: registered anode, digit value and decimal point for current slot
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_idx  <= 2'd0;
         digit_an  <= 4'b1110;
         digit_bcd <= 4'd0;
         dp_n      <= 1'b1;
      end else begin
         if (scan_tick) scan_idx <= scan_idx + 2'd1;
         case (scan_idx)
            2'd0: begin digit_an <= 4'b1110; digit_bcd <= disp_src[3:0];   dp_n <= 1'b1; end
            2'd1: begin digit_an <= 4'b1101; digit_bcd <= disp_src[7:4];   dp_n <= 1'b1; end
            2'd2: begin digit_an <= 4'b1011; digit_bcd <= disp_src[11:8];  dp_n <= 1'b0; end
            default: begin digit_an <= 4'b0111; digit_bcd <= disp_src[15:12]; dp_n <= 1'b1; end
         endcase
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl against a count-based model
module tb_stopwatch_ctrl;

   localparam int FULL = 5999;
   localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick = 1'b0, scan_tick = 1'b0;
   logic        btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
   logic [15:0] time_bcd, time_bcd_s;
   logic [3:0]  digit_an, digit_bcd, digit_an_s, digit_bcd_s;
   logic        dp_n, running, lap_active, ovf;
   logic        dp_n_s, running_s, lap_active_s, ovf_s;

   int n_pass = 0, n_total = 0;

   // model state: counts in hundredths, not BCD
   int   m_st, m_cnt, m_sat, m_lap, m_idx;
   logic m_ovf, m_ovf_sat, m_qs, m_ql, m_qc;
   logic [3:0] m_an, m_bcd;
   logic       m_dp;

   stopwatch_ctrl #(.SEC_TENS_MAX(5), .WRAP(1'b1)) dut (
      .clk(clk), .reset(reset), .tick(tick), .scan_tick(scan_tick),
      .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
      .time_bcd(time_bcd), .digit_an(digit_an), .digit_bcd(digit_bcd), .dp_n(dp_n),
      .running(running), .lap_active(lap_active), .ovf(ovf));

   stopwatch_ctrl #(.SEC_TENS_MAX(5), .WRAP(1'b0)) dut_sat (
      .clk(clk), .reset(reset), .tick(tick), .scan_tick(scan_tick),
      .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
      .time_bcd(time_bcd_s), .digit_an(digit_an_s), .digit_bcd(digit_bcd_s), .dp_n(dp_n_s),
      .running(running_s), .lap_active(lap_active_s), .ovf(ovf_s));

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int c);
      logic [15:0] r;
      r[15:12] = 4'(c / 1000);
      r[11:8]  = 4'((c / 100) % 10);
      r[7:4]   = 4'((c / 10) % 10);
      r[3:0]   = 4'(c % 10);
      return r;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_cnt = 0; m_sat = 0; m_lap = 0; m_idx = 0;
      m_ovf = 0; m_ovf_sat = 0; m_qs = 0; m_ql = 0; m_qc = 0;
      m_an = 4'b1110; m_bcd = 4'd0; m_dp = 1'b1;
   endtask

   task automatic model_edge();
      logic ec, es, el;
      int   src, ns;
      ec = btn_clr & ~m_qc;
      es = btn_ss & ~m_qs & ~ec;
      el = btn_lap & ~m_ql & ~ec & ~(btn_ss & ~m_qs);
      src = (m_st == M_LAP) ? m_lap : m_cnt;
      m_an  = ~(4'b0001 << m_idx);
      m_dp  = (m_idx != 2);
      m_bcd = 4'((src / (10 ** m_idx)) % 10);
      if (scan_tick) m_idx = (m_idx + 1) % 4;
      ns = m_st;
      case (m_st)
         M_IDLE:  if (es) ns = M_RUN;
         M_RUN:   if (es) ns = M_PAUSE; else if (el) begin ns = M_LAP; m_lap = m_cnt; end
         M_LAP:   if (es) ns = M_PAUSE; else if (el) ns = M_RUN;
         default: if (ec) ns = M_IDLE; else if (es) ns = M_RUN;
      endcase
      if (tick && (m_st == M_RUN || m_st == M_LAP)) begin
         if (m_cnt == FULL) begin m_cnt = 0; m_ovf = 1; end else m_cnt++;
         if (m_sat == FULL) m_ovf_sat = 1; else m_sat++;
      end
      if (m_st == M_PAUSE && ec) begin
         m_cnt = 0; m_sat = 0; m_ovf = 0; m_ovf_sat = 0;
      end
      m_st = ns;
      m_qs = btn_ss; m_ql = btn_lap; m_qc = btn_clr;
   endtask

   task automatic cycle(input logic s, input logic l, input logic c, input logic t, input logic sc);
      @(negedge clk);
      btn_ss = s; btn_lap = l; btn_clr = c; tick = t; scan_tick = sc;
      @(posedge clk);
      if (reset) model_reset(); else model_edge();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle(0, 0, 0, 0, 0);
      reset = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 0);
   endtask

   task automatic read_display(output logic [15:0] v);
      v = 16'hxxxx;
      for (int k = 0; k < 4; k++) begin
         cycle(0, 0, 0, 0, 1);
         case (digit_an)
            4'b1110: v[3:0]   = digit_bcd;
            4'b1101: v[7:4]   = digit_bcd;
            4'b1011: v[11:8]  = digit_bcd;
            4'b0111: v[15:12] = digit_bcd;
            default: ;
         endcase
      end
   endtask

   task automatic test_reset();
      tick = 1; btn_ss = 0;
      cycle(1, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 1);
      do_reset();
      n_total++; if ({time_bcd, ovf, running, lap_active} !== {16'h0, 3'b000})
         $display("FAIL reset_state: got t=%h ovf=%b run=%b lap=%b, need 0000/0/0/0", time_bcd, ovf, running, lap_active);
      else n_pass++;
      n_total++; if ({digit_an, digit_bcd, dp_n} !== {4'b1110, 4'd0, 1'b1})
         $display("FAIL reset_display: got an=%b bcd=%h dp=%b, need 1110/0/1", digit_an, digit_bcd, dp_n);
      else n_pass++;
   endtask

   task automatic test_count();
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      run_ticks(150);
      n_total++; if (running !== 1'b1 || time_bcd !== 16'h0150)
         $display("FAIL count_150: got run=%b t=%h, need 1/0150", running, time_bcd);
      else n_pass++;
   endtask

   task automatic test_lap();
      logic [15:0] v;
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      run_ticks(25);
      n_total++; if (time_bcd !== 16'h0175 || lap_active !== 1'b1)
         $display("FAIL lap_live: got t=%h lap=%b, need 0175/1", time_bcd, lap_active);
      else n_pass++;
      read_display(v);
      n_total++; if (v !== 16'h0150)
         $display("FAIL lap_frozen_display: got %h, need 0150", v);
      else n_pass++;
      cycle(0, 1, 0, 0, 0);
      read_display(v);
      n_total++; if (v !== 16'h0175 || lap_active !== 1'b0 || running !== 1'b1)
         $display("FAIL lap_release: got disp=%h lap=%b run=%b, need 0175/0/1", v, lap_active, running);
      else n_pass++;
   endtask

   task automatic test_clear();
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0);
      n_total++; if (running !== 1'b1 || time_bcd !== 16'h0175)
         $display("FAIL clr_in_run: got run=%b t=%h, need 1/0175", running, time_bcd);
      else n_pass++;
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      n_total++; if (running !== 1'b0 || time_bcd !== 16'h0000)
         $display("FAIL clr_in_pause: got run=%b t=%h, need 0/0000", running, time_bcd);
      else n_pass++;
      cycle(0, 0, 0, 0, 0);
   endtask

   task automatic test_overflow();
      do_reset();
      cycle(1, 0, 0, 0, 0);
      run_ticks(FULL);
      n_total++; if (time_bcd !== 16'h5999 || time_bcd_s !== 16'h5999 || ovf !== 1'b0)
         $display("FAIL full_scale: got t=%h ts=%h ovf=%b, need 5999/5999/0", time_bcd, time_bcd_s, ovf);
      else n_pass++;
      run_ticks(1);
      n_total++; if (time_bcd !== 16'h0000 || ovf !== 1'b1)
         $display("FAIL wrap: got t=%h ovf=%b, need 0000/1", time_bcd, ovf);
      else n_pass++;
      run_ticks(1);
      n_total++; if (time_bcd_s !== 16'h5999 || ovf_s !== 1'b1 || time_bcd !== 16'h0001)
         $display("FAIL saturate: got ts=%h ovfs=%b t=%h, need 5999/1/0001", time_bcd_s, ovf_s, time_bcd);
      else n_pass++;
   endtask

   task automatic test_same_cycle();
      do_reset();
      cycle(1, 0, 0, 0, 0);
      run_ticks(10);
      cycle(1, 0, 0, 1, 0);
      n_total++; if (running !== 1'b0 || time_bcd !== 16'h0011)
         $display("FAIL stop_with_tick: got run=%b t=%h, need 0/0011", running, time_bcd);
      else n_pass++;
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 1, 0);
      n_total++; if (running !== 1'b1 || time_bcd !== 16'h0011)
         $display("FAIL start_with_tick: got run=%b t=%h, need 1/0011", running, time_bcd);
      else n_pass++;
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 1, 0, 0);
      n_total++; if (running !== 1'b0 || time_bcd !== 16'h0000)
         $display("FAIL clr_beats_ss: got run=%b t=%h, need 0/0000", running, time_bcd);
      else n_pass++;
      cycle(0, 0, 0, 0, 0);
   endtask

   task automatic test_scan();
      logic [8:0] exp_tab [4];
      exp_tab[0] = {4'b1101, 4'd3, 1'b1};
      exp_tab[1] = {4'b1011, 4'd2, 1'b0};
      exp_tab[2] = {4'b0111, 4'd1, 1'b1};
      exp_tab[3] = {4'b1110, 4'd4, 1'b1};
      do_reset();
      cycle(1, 0, 0, 0, 0);
      run_ticks(1234);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         cycle(0, 0, 0, 0, 1);
         cycle(0, 0, 0, 0, 0);
         n_total++; if ({digit_an, digit_bcd, dp_n} !== exp_tab[k])
            $display("FAIL scan_%0d: got an=%b bcd=%h dp=%b, need %b", k, digit_an, digit_bcd, dp_n, exp_tab[k]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) reset = 1'b1;
         cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0);
         reset = 1'b0;
         if (time_bcd !== to_bcd(m_cnt) || time_bcd_s !== to_bcd(m_sat) || ovf !== m_ovf ||
             ovf_s !== m_ovf_sat || running !== (m_st == M_RUN || m_st == M_LAP) ||
             lap_active !== (m_st == M_LAP) || digit_an !== m_an || digit_bcd !== m_bcd ||
             dp_n !== m_dp) begin
            if (bad < 5)
               $display("FAIL random_cyc%0d: got t=%h ts=%h ovf=%b run=%b lap=%b an=%b bcd=%h dp=%b, need t=%h ts=%h ovf=%b st=%0d an=%b bcd=%h dp=%b",
                        i, time_bcd, time_bcd_s, ovf, running, lap_active, digit_an, digit_bcd, dp_n,
                        to_bcd(m_cnt), to_bcd(m_sat), m_ovf, m_st, m_an, m_bcd, m_dp);
            bad++;
         end
      end
      n_total++; if (bad != 0)
         $display("FAIL random_total: got %0d mismatching cycles, need 0", bad);
      else n_pass++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_count();
      test_lap();
      test_clear();
      test_overflow();
      test_same_cycle();
      test_scan();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
